cmp_branch_unit: RTL and testbench
==================================

CMP_BRANCH_UNIT -- requirements
Module: cmp_branch_unit

Interface
REQ-001 Parameter DW, default 8, operand and result width.
REQ-002 Parameter AW, default 8, program-counter and target width.
REQ-003 Parameter SIGNED, default 0; 0 selects unsigned compares, 1 selects two's-complement compares.
REQ-004 Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-005 Parameter CW, default 8, width of the taken-branch counter.
REQ-006 One clock; reset is asynchronous and active-high. Ports are clk and rst.
REQ-007 clk  input  1  rising-edge clock.
REQ-008 rst  input  1  asynchronous active-high reset.
REQ-009 en  input  1  instruction valid this cycle.
REQ-010 opcode  input  3  000 LT, 001 GT, 010 EQ, 011 GTE, 100 LTE, 101 NE, 110 BE, 111 BNE.
REQ-011 R1, R2  input  DW each  compare operands.
REQ-012 target  input  AW  branch target, absolute or signed offset.
REQ-013 rel  input  1  1 = relative branch (pc+target), 0 = absolute.
REQ-014 RD  output  DW  registered compare result, zero-extended 0 or 1.
REQ-015 flag  output  1  stored condition flag.
REQ-016 pc  output  AW  program counter.
REQ-017 taken  output  1  one-cycle pulse on a taken branch.
REQ-018 flush  output  1  high while the FLUSH state discards the instruction.
REQ-019 taken_cnt  output  CW  saturating count of taken branches.

Function
REQ-020 The FSM has two states, RUN and FLUSH.
REQ-021 In RUN with en=1 and a compare opcode (000-101), on the clock edge: RD <= {DW-1 zeros, cond}; flag <= cond; pc <= pc+1.
REQ-022 The compare condition is computed unsigned when SIGNED=0 and signed when SIGNED=1 (e.g. DW=8, R1=8'hFF, R2=8'h01: LT=0 unsigned, LT=1 signed).
REQ-023 In RUN with en=1 and BE, the branch is taken iff flag=1. With BNE, it is taken iff flag=0. RD and flag hold.
REQ-024 When a branch is taken: pc <= rel ? pc+target : target; taken=1 for exactly the next cycle; state <= FLUSH; taken_cnt increments unless it is all-ones.
REQ-025 When a branch is not taken: pc <= pc+1; taken=0; state stays RUN.
REQ-026 For relative branches, target is a two's-complement offset. The AW-bit addition wraps modulo 2^AW.
REQ-027 pc+1 wraps from all-ones to 0.
REQ-028 In RUN with en=0, all registers hold and taken=0.
REQ-029 FLUSH lasts exactly one cycle with flush=1. In FLUSH, en, opcode, and operands are ignored; pc, RD, flag, and taken_cnt hold; the next state is RUN.
REQ-030 The flag read by BE/BNE is the registered value from the most recent compare. There is no same-cycle forwarding.
REQ-031 taken_cnt saturates at 2^CW-1 and never wraps.
REQ-032 All outputs are registered. Latency from the instruction edge to the RD/flag/pc update is one clock.

Reset
REQ-033 rst=1 immediately forces pc=RESET_PC, RD=0, flag=0, taken=0, flush=0, taken_cnt=0, and state=RUN, independent of clk.
REQ-034 Reset asserted in FLUSH or mid-sequence aborts the operation. The first edge after deassertion is treated as RUN.

Verification
REQ-035 Unsigned compares (DW=8): LT 3,5 -> RD=1, flag=1; LT 5,3 -> RD=0; EQ 2,2 -> RD=1; NE 2,2 -> RD=0; GTE 4,4 -> RD=1; LTE 7,3 -> RD=0; pc advances by 1 per instruction.
REQ-036 SIGNED=1, LT R1=8'hFF, R2=8'h01 -> RD=1. With SIGNED=0, the same stimulus gives RD=0.
REQ-037 From pc=8'h10: EQ 2,2 then BE with target=8'h40, rel=0 -> pc=8'h40, taken pulses 1 cycle, flush=1 next cycle, and a GT 9,1 presented during flush leaves RD unchanged.
REQ-038 From pc=8'h05, flag=0: BNE with rel=1, target=8'hFE -> pc=8'h03. Then BE -> not taken, pc=8'h04, taken=0.
REQ-039 pc=8'hFF with a compare -> pc=8'h00. With CW=2, four taken branches -> taken_cnt stays at 3.
REQ-040 Assert rst during FLUSH -> pc=RESET_PC, flush=0, and counts=0 before the next edge. After release, EQ 1,1 executes normally.

Source files
------------

// File: rtl/cmp_branch_unit.sv
// Compare-and-branch unit: registers compare results into RD/flag and resolves
// BE/BNE branches against the stored flag. A taken branch is followed by one flush cycle.
module cmp_branch_unit #(
  parameter int DW       = 8,
  parameter int AW       = 8,
  parameter int SIGNED   = 0,
  parameter int RESET_PC = 0,
  parameter int CW       = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [2:0]    opcode,
  input  logic [DW-1:0] R1,
  input  logic [DW-1:0] R2,
  input  logic [AW-1:0] target,
  input  logic          rel,
  output logic [DW-1:0] RD,
  output logic          flag,
  output logic [AW-1:0] pc,
  output logic          taken,
  output logic          flush,
  output logic [CW-1:0] taken_cnt
);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] rd_nxt;
  logic          flag_nxt;
  logic [AW-1:0] pc_nxt;
  logic          taken_nxt;
  logic [CW-1:0] cnt_nxt;
  logic          take;

  function automatic logic compare(input logic [2:0] op, input logic [DW-1:0] a,
                                   input logic [DW-1:0] b);
    logic signed [DW-1:0] sa;
    logic signed [DW-1:0] sb;
    logic lt;
    logic eq;
    sa = a;
    sb = b;
    lt = (SIGNED != 0) ? (sa < sb) : (a < b);
    eq = (a == b);
    case (op)
      3'b000:  compare = lt;
      3'b001:  compare = !lt && !eq;
      3'b010:  compare = eq;
      3'b011:  compare = !lt;
      3'b100:  compare = lt || eq;
      3'b101:  compare = !eq;
      default: compare = 1'b0;
    endcase
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    sat_inc = (&c) ? c : c + CW'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      RD        <= '0;
      flag      <= 1'b0;
      pc        <= AW'(RESET_PC);
      taken     <= 1'b0;
      taken_cnt <= '0;
    end else begin
      state     <= state_nxt;
      RD        <= rd_nxt;
      flag      <= flag_nxt;
      pc        <= pc_nxt;
      taken     <= taken_nxt;
      taken_cnt <= cnt_nxt;
    end
  end

  assign flush = (state == FLUSH);

  // BE (110) takes on flag=1, BNE (111) on flag=0; flag is last edge's compare result
  assign take = opcode[0] ? !flag : flag;

  always_comb begin
    state_nxt = state;
    rd_nxt    = RD;
    flag_nxt  = flag;
    pc_nxt    = pc;
    taken_nxt = 1'b0;
    cnt_nxt   = taken_cnt;
    case (state)
      RUN: begin
        if (en) begin
          if (opcode[2:1] != 2'b11) begin
            rd_nxt    = '0;
            rd_nxt[0] = compare(opcode, R1, R2);
            flag_nxt  = rd_nxt[0];
            pc_nxt    = pc + AW'(1);
          end else if (take) begin
            pc_nxt    = rel ? pc + target : target;
            taken_nxt = 1'b1;
            state_nxt = FLUSH;
            cnt_nxt   = sat_inc(taken_cnt);
          end else begin
            pc_nxt = pc + AW'(1);
          end
        end
      end
      FLUSH: state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

endmodule

// File: tb/tb_cmp_branch_unit.sv
// Directed bench for cmp_branch_unit: an unsigned/CW=8 instance and a signed/CW=2
// instance share stimulus; compare table plus hand-written branch/flush/reset sequences.
module tb_cmp_branch_unit;

  logic       clk, rst, en, rel;
  logic [2:0] opcode;
  logic [7:0] R1, R2, target;

  logic [7:0] rd0, pc0, cnt0, rd1, pc1;
  logic       flag0, taken0, flush0, flag1, taken1, flush1;
  logic [1:0] cnt1;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] LT = 3'b000, GT = 3'b001, EQ = 3'b010, GTE = 3'b011,
                         LTE = 3'b100, NE = 3'b101, BE = 3'b110, BNE = 3'b111;

  cmp_branch_unit #(.DW(8), .AW(8), .SIGNED(0), .RESET_PC(0), .CW(8)) dut0 (
    .clk(clk), .rst(rst), .en(en), .opcode(opcode), .R1(R1), .R2(R2),
    .target(target), .rel(rel), .RD(rd0), .flag(flag0), .pc(pc0),
    .taken(taken0), .flush(flush0), .taken_cnt(cnt0));

  cmp_branch_unit #(.DW(8), .AW(8), .SIGNED(1), .RESET_PC(0), .CW(2)) dut1 (
    .clk(clk), .rst(rst), .en(en), .opcode(opcode), .R1(R1), .R2(R2),
    .target(target), .rel(rel), .RD(rd1), .flag(flag1), .pc(pc1),
    .taken(taken1), .flush(flush1), .taken_cnt(cnt1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       exp_u;
    logic       exp_s;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] t, input logic r);
    en = e; opcode = op; R1 = a; R2 = b; target = t; rel = r;
  endtask

  task automatic check_ctl(input string name, input logic [7:0] epc, input logic etk,
                           input logic efl, input logic [7:0] ec0, input logic [1:0] ec1);
    chk({name, ".pc0"}, 32'(pc0), 32'(epc));
    chk({name, ".pc1"}, 32'(pc1), 32'(epc));
    chk({name, ".taken"}, 32'({taken0, taken1}), 32'({etk, etk}));
    chk({name, ".flush"}, 32'({flush0, flush1}), 32'({efl, efl}));
    chk({name, ".cnt0"}, 32'(cnt0), 32'(ec0));
    chk({name, ".cnt1"}, 32'(cnt1), 32'(ec1));
  endtask

  task automatic check_rd(input string name, input logic e0, input logic e1);
    chk({name, ".rd0"}, 32'(rd0), 32'(e0));
    chk({name, ".flag0"}, 32'(flag0), 32'(e0));
    chk({name, ".rd1"}, 32'(rd1), 32'(e1));
    chk({name, ".flag1"}, 32'(flag1), 32'(e1));
  endtask

  initial begin
    vecs[0] = '{LT,  8'd3,   8'd5, 1'b1, 1'b1};
    vecs[1] = '{LT,  8'd5,   8'd3, 1'b0, 1'b0};
    vecs[2] = '{EQ,  8'd2,   8'd2, 1'b1, 1'b1};
    vecs[3] = '{NE,  8'd2,   8'd2, 1'b0, 1'b0};
    vecs[4] = '{GTE, 8'd4,   8'd4, 1'b1, 1'b1};
    vecs[5] = '{LTE, 8'd7,   8'd3, 1'b0, 1'b0};
    vecs[6] = '{LT,  8'hFF,  8'h01, 1'b0, 1'b1};
    vecs[7] = '{GT,  8'd9,   8'd1, 1'b1, 1'b1};

    rst = 1'b1;
    drive(1'b0, LT, 8'd0, 8'd0, 8'd0, 1'b0);
    #1;
    check_ctl("reset", 8'h00, 1'b0, 1'b0, 8'd0, 2'd0);
    check_rd("reset", 1'b0, 1'b0);
    step();
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 8'd0, 1'b0);
      step();
      check_rd($sformatf("vec%0d", i), vecs[i].exp_u, vecs[i].exp_s);
      chk($sformatf("vec%0d.pc", i), 32'(pc0), 32'(i + 1));
    end

    // en=0 holds everything
    drive(1'b0, LT, 8'd9, 8'd1, 8'd0, 1'b0);
    step();
    check_ctl("hold", 8'h08, 1'b0, 1'b0, 8'd0, 2'd0);
    check_rd("hold", 1'b1, 1'b1);

    // absolute BE to 0x10, then idle through flush
    drive(1'b1, BE, 8'd0, 8'd0, 8'h10, 1'b0);
    step();
    check_ctl("be10", 8'h10, 1'b1, 1'b1, 8'd1, 2'd1);
    drive(1'b0, LT, 8'd0, 8'd0, 8'd0, 1'b0);
    step();
    check_ctl("be10.after", 8'h10, 1'b0, 1'b0, 8'd1, 2'd1);

    drive(1'b1, EQ, 8'd2, 8'd2, 8'd0, 1'b0);
    step();
    check_rd("eq22", 1'b1, 1'b1);
    drive(1'b1, BE, 8'd0, 8'd0, 8'h40, 1'b0);
    step();
    check_ctl("be40", 8'h40, 1'b1, 1'b1, 8'd2, 2'd2);
    // instruction presented during flush must be discarded
    drive(1'b1, NE, 8'd2, 8'd2, 8'd0, 1'b0);
    step();
    check_ctl("flushed", 8'h40, 1'b0, 1'b0, 8'd2, 2'd2);
    check_rd("flushed", 1'b1, 1'b1);

    drive(1'b1, NE, 8'd2, 8'd2, 8'd0, 1'b0);
    step();
    check_rd("ne22", 1'b0, 1'b0);
    drive(1'b1, BNE, 8'd0, 8'd0, 8'h05, 1'b0);
    step();
    check_ctl("bne05", 8'h05, 1'b1, 1'b1, 8'd3, 2'd3);
    drive(1'b0, LT, 8'd0, 8'd0, 8'd0, 1'b0);
    step();

    drive(1'b1, BNE, 8'd0, 8'd0, 8'hFE, 1'b1);
    step();
    check_ctl("bnerel", 8'h03, 1'b1, 1'b1, 8'd4, 2'd3);
    drive(1'b0, LT, 8'd0, 8'd0, 8'd0, 1'b0);
    step();
    drive(1'b1, BE, 8'd0, 8'd0, 8'h33, 1'b0);
    step();
    check_ctl("be.nt", 8'h04, 1'b0, 1'b0, 8'd4, 2'd3);

    drive(1'b1, BNE, 8'd0, 8'd0, 8'hFF, 1'b0);
    step();
    check_ctl("bneff", 8'hFF, 1'b1, 1'b1, 8'd5, 2'd3);
    drive(1'b0, LT, 8'd0, 8'd0, 8'd0, 1'b0);
    step();
    drive(1'b1, EQ, 8'd1, 8'd1, 8'd0, 1'b0);
    step();
    check_ctl("wrap", 8'h00, 1'b0, 1'b0, 8'd5, 2'd3);
    check_rd("wrap", 1'b1, 1'b1);

    // reset while in FLUSH takes effect before the next edge
    drive(1'b1, BE, 8'd0, 8'd0, 8'h20, 1'b0);
    step();
    check_ctl("be20", 8'h20, 1'b1, 1'b1, 8'd6, 2'd3);
    rst = 1'b1;
    #1;
    check_ctl("rstflush", 8'h00, 1'b0, 1'b0, 8'd0, 2'd0);
    check_rd("rstflush", 1'b0, 1'b0);
    #1;
    rst = 1'b0;
    drive(1'b1, EQ, 8'd1, 8'd1, 8'd0, 1'b0);
    step();
    check_ctl("postrst", 8'h01, 1'b0, 1'b0, 8'd0, 2'd0);
    check_rd("postrst", 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
